// File: rtl/ttl_pkg.sv
// ----------------------------------------------------------------------------
// ttl_pkg
// Shared definitions for the synchronous TTL-emulation models.
//   MODE_*  : 2-bit mode codes for universal shift registers
//             (74LS194/299-style S[1:0] control).
// ----------------------------------------------------------------------------
package ttl_pkg;

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SHR  = 2'b01;
    localparam logic [1:0] MODE_SHL  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

endpackage

// File: rtl/ttl_cen_qual.sv
// ----------------------------------------------------------------------------
// ttl_cen_qual
// Qualifies a chip-clock strobe (Cen) into a single-clk action enable.
//   CEN_EDGE = 1 : act on the rising edge of Cen (one action per strobe,
//                  regardless of how long Cen stays high).
//   CEN_EDGE = 0 : act on every clk with Cen high.
// Ports:
//   clk      in   system clock
//   Reset_n  in   synchronous reset, active-low
//   i_cen    in   chip-clock strobe
//   o_act    out  qualified action enable (combinational from i_cen)
// ----------------------------------------------------------------------------
module ttl_cen_qual #(
    parameter bit CEN_EDGE = 1'b1
) (
    input  logic clk,
    input  logic Reset_n,
    input  logic i_cen,
    output logic o_act
);

    logic r_last_cen;

    // Reset value of 1 means a Cen that is already high when reset is
    // released is not seen as a rising edge.
    always_ff @(posedge clk) begin
        if (!Reset_n) begin
            r_last_cen <= 1'b1;
        end else begin
            r_last_cen <= i_cen;
        end
    end

    generate
        if (CEN_EDGE) begin : g_edge
            assign o_act = i_cen & ~r_last_cen;
        end else begin : g_level
            assign o_act = i_cen;
        end
    endgenerate

endmodule

// File: rtl/ttl_univ_shiftreg_sync.sv
// ----------------------------------------------------------------------------
// ttl_univ_shiftreg_sync
// Parametrised synchronous universal shift register (74LS164/194/299 style)
// for TTL-emulation logic running on the system clock.
// Ports:
//   clk        in   system clock, all state changes on posedge
//   Reset_n    in   synchronous reset, active-low (highest priority)
//   Cen        in   chip-clock strobe, qualified per CEN_EDGE
//   MRn        in   master reset, active-low, synchronous
//   S[1:0]     in   mode: 00 hold, 01 shift right, 10 shift left, 11 load
//   DSR_A/B    in   right-shift serial data, gated as DSR_A & DSR_B
//   DSL        in   left-shift serial data
//   D          in   parallel load data
//   Q          out  register contents, Q[0] is the first right-shift stage
//   QSR        out  Q[WIDTH-1]
//   QSL        out  Q[0]
//   shift_evt  out  registered pulse, high the cycle after a qualified
//                   non-hold action
// ----------------------------------------------------------------------------
module ttl_univ_shiftreg_sync
    import ttl_pkg::*;
#(
    parameter int               WIDTH    = 8,
    parameter bit               CEN_EDGE = 1'b1,
    parameter logic [WIDTH-1:0] INIT_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             Reset_n,
    input  logic             Cen,
    input  logic             MRn,
    input  logic [1:0]       S,
    input  logic             DSR_A,
    input  logic             DSR_B,
    input  logic             DSL,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             QSR,
    output logic             QSL,
    output logic             shift_evt
);

    logic [WIDTH-1:0] r_q;
    logic             r_shift_evt;
    logic             w_act;
    logic             w_dsr;
    logic [WIDTH-1:0] w_shr;
    logic [WIDTH-1:0] w_shl;

    ttl_cen_qual #(
        .CEN_EDGE (CEN_EDGE)
    ) u_cen_qual (
        .clk     (clk),
        .Reset_n (Reset_n),
        .i_cen   (Cen),
        .o_act   (w_act)
    );

    // 74164-compatible gated serial input.
    assign w_dsr = DSR_A & DSR_B;

    // Candidate next values for both shift directions.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_shift
            if (gi == 0) begin : g_shr_first
                assign w_shr[gi] = w_dsr;
            end else begin : g_shr_mid
                assign w_shr[gi] = r_q[gi-1];
            end
            if (gi == WIDTH - 1) begin : g_shl_last
                assign w_shl[gi] = DSL;
            end else begin : g_shl_mid
                assign w_shl[gi] = r_q[gi+1];
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!Reset_n) begin
            r_q         <= INIT_VAL;
            r_shift_evt <= 1'b0;
        end else if (!MRn) begin
            r_q         <= INIT_VAL;
            r_shift_evt <= 1'b0;
        end else begin
            r_shift_evt <= w_act && (S != MODE_HOLD);
            if (w_act) begin
                case (S)
                    MODE_SHR:  r_q <= w_shr;
                    MODE_SHL:  r_q <= w_shl;
                    MODE_LOAD: r_q <= D;
                    default:   r_q <= r_q;
                endcase
            end
        end
    end

    assign Q         = r_q;
    assign QSR       = r_q[WIDTH-1];
    assign QSL       = r_q[0];
    assign shift_evt = r_shift_evt;

endmodule

// File: tb/tb_ttl_univ_shiftreg_sync.sv
// ----------------------------------------------------------------------------
// tb_ttl_univ_shiftreg_sync
// Three instances share one stimulus stream:
//   u_e8 : WIDTH 8, rising-edge qualification
//   u_l8 : WIDTH 8, level qualification
//   u_e4 : WIDTH 4, rising-edge qualification, INIT_VAL 4'b1010
// A behavioural model tracks all three and is compared on every negedge;
// directed literal checks pin the model to hand-computed values.
// ----------------------------------------------------------------------------
module tb_ttl_univ_shiftreg_sync;

    localparam int N = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, cen, mrn, dsra, dsrb, dsl;
    logic [1:0] s;
    logic [7:0] d;

    logic [7:0] q_e8, q_l8;
    logic [3:0] q_e4;
    logic       qsr_e8, qsl_e8, evt_e8;
    logic       qsr_l8, qsl_l8, evt_l8;
    logic       qsr_e4, qsl_e4, evt_e4;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    ttl_univ_shiftreg_sync #(.WIDTH(8), .CEN_EDGE(1'b1), .INIT_VAL(8'h00)) u_e8 (
        .clk(clk), .Reset_n(rst_n), .Cen(cen), .MRn(mrn), .S(s),
        .DSR_A(dsra), .DSR_B(dsrb), .DSL(dsl), .D(d),
        .Q(q_e8), .QSR(qsr_e8), .QSL(qsl_e8), .shift_evt(evt_e8));

    ttl_univ_shiftreg_sync #(.WIDTH(8), .CEN_EDGE(1'b0), .INIT_VAL(8'h00)) u_l8 (
        .clk(clk), .Reset_n(rst_n), .Cen(cen), .MRn(mrn), .S(s),
        .DSR_A(dsra), .DSR_B(dsrb), .DSL(dsl), .D(d),
        .Q(q_l8), .QSR(qsr_l8), .QSL(qsl_l8), .shift_evt(evt_l8));

    ttl_univ_shiftreg_sync #(.WIDTH(4), .CEN_EDGE(1'b1), .INIT_VAL(4'b1010)) u_e4 (
        .clk(clk), .Reset_n(rst_n), .Cen(cen), .MRn(mrn), .S(s),
        .DSR_A(dsra), .DSR_B(dsrb), .DSL(dsl), .D(d[3:0]),
        .Q(q_e4), .QSR(qsr_e4), .QSL(qsl_e4), .shift_evt(evt_e4));

    // ------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------
    int unsigned m_width [N] = '{8, 8, 4};
    bit          m_edge  [N] = '{1'b1, 1'b0, 1'b1};
    int unsigned m_init  [N] = '{32'h0, 32'h0, 32'hA};

    int unsigned m_q    [N];
    bit          m_last [N];
    bit          m_evt  [N];

    function automatic int unsigned model_next(int unsigned q, int unsigned w,
                                               logic [1:0] mode, bit sr_bit,
                                               bit sl_bit, int unsigned dval);
        int unsigned mask;
        mask = (32'h1 << w) - 1;
        case (mode)
            2'b01:   return ((q * 2) + sr_bit) & mask;             // toward MSB
            2'b10:   return (q / 2) + (sl_bit ? (32'h1 << (w - 1)) : 0);
            2'b11:   return dval & mask;
            default: return q;
        endcase
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            automatic bit a = m_edge[i] ? (cen && !m_last[i]) : cen;
            if (!rst_n) begin
                m_q[i]    <= m_init[i];
                m_last[i] <= 1'b1;
                m_evt[i]  <= 1'b0;
            end else begin
                m_last[i] <= cen;
                if (!mrn) begin
                    m_q[i]   <= m_init[i];
                    m_evt[i] <= 1'b0;
                end else begin
                    m_evt[i] <= a && (s != 2'b00);
                    if (a)
                        m_q[i] <= model_next(m_q[i], m_width[i], s, dsra & dsrb,
                                             dsl, 32'(d));
                end
            end
        end
    end

    task automatic do_check(string name, int unsigned got, int unsigned exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Continuous compare on the falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            do_check("model_q_e8",   32'(q_e8),   m_q[0]);
            do_check("model_qsr_e8", 32'(qsr_e8), (m_q[0] >> 7) & 1);
            do_check("model_qsl_e8", 32'(qsl_e8), m_q[0] & 1);
            do_check("model_evt_e8", 32'(evt_e8), 32'(m_evt[0]));
            do_check("model_q_l8",   32'(q_l8),   m_q[1]);
            do_check("model_qsr_l8", 32'(qsr_l8), (m_q[1] >> 7) & 1);
            do_check("model_qsl_l8", 32'(qsl_l8), m_q[1] & 1);
            do_check("model_evt_l8", 32'(evt_l8), 32'(m_evt[1]));
            do_check("model_q_e4",   32'(q_e4),   m_q[2]);
            do_check("model_qsr_e4", 32'(qsr_e4), (m_q[2] >> 3) & 1);
            do_check("model_qsl_e4", 32'(qsl_e4), m_q[2] & 1);
            do_check("model_evt_e4", 32'(evt_e4), 32'(m_evt[2]));
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers: inputs change 2 time units after posedge.
    // ------------------------------------------------------------------
    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // One Cen strobe: 1 clk high, 3 clk low. shift_evt is checked in the
    // cycle right after the acting edge.
    task automatic pulse();
        cen = 1'b1;
        tick(1);
        do_check("lit_evt_e8", 32'(evt_e8), (s != 2'b00) ? 1 : 0);
        cen = 1'b0;
        tick(3);
    endtask

    initial begin
        rst_n = 1'b0; cen = 1'b1; mrn = 1'b1; s = 2'b01;
        dsra = 1'b1; dsrb = 1'b1; dsl = 1'b0; d = 8'h00;

        // Reset held 2 clk with Cen high, released with Cen still high.
        tick(1);
        chk_en = 1'b1;
        tick(1);
        rst_n = 1'b1;
        tick(1);
        do_check("lit_reset_q_e8",   32'(q_e8),   32'h00);
        do_check("lit_reset_evt_e8", 32'(evt_e8), 32'h0);
        cen = 1'b0;
        tick(1);

        // Shift right with serial 1: 01, 03, 07 ... FF.
        for (int k = 1; k <= 8; k++) begin
            pulse();
            do_check($sformatf("lit_shr_%0d", k), 32'(q_e8), (32'h1 << k) - 1);
        end
        do_check("lit_qsr_after8", 32'(qsr_e8), 32'h1);
        dsrb = 1'b0;
        pulse();
        do_check("lit_shr_gated", 32'(q_e8), 32'hFE);
        dsrb = 1'b1;

        // Load then shift left.
        s = 2'b11; d = 8'hA5;
        pulse();
        do_check("lit_load_a5", 32'(q_e8), 32'hA5);
        s = 2'b10; dsl = 1'b0;
        pulse();
        do_check("lit_shl_52",  32'(q_e8),   32'h52);
        do_check("lit_shl_qsl", 32'(qsl_e8), 32'h0);

        // MRn coincident with a Cen edge, then released with Cen high.
        s = 2'b11; d = 8'hFF;
        pulse();
        do_check("lit_load_ff", 32'(q_e8), 32'hFF);
        s = 2'b01; cen = 1'b1; mrn = 1'b0;
        tick(1);
        do_check("lit_mrn_clear", 32'(q_e8), 32'h00);
        mrn = 1'b1;
        tick(3);
        do_check("lit_mrn_hold",  32'(q_e8), 32'h00);
        cen = 1'b0;
        tick(1);
        pulse();
        do_check("lit_mrn_next",  32'(q_e8), 32'h01);

        // Edge vs level: Cen high for 5 clk, serial 1, starting from 0.
        mrn = 1'b0;
        tick(1);
        mrn = 1'b1; s = 2'b01; dsra = 1'b1; dsrb = 1'b1; cen = 1'b1;
        tick(5);
        do_check("lit_edge_q",  32'(q_e8), 32'h01);
        do_check("lit_level_q", 32'(q_l8), 32'h1F);
        cen = 1'b0;
        tick(1);

        // Narrow instance: INIT 1010, shift left with DSL = 1 twice.
        mrn = 1'b0;
        tick(1);
        do_check("lit_w4_init", 32'(q_e4), 32'hA);
        mrn = 1'b1; s = 2'b10; dsl = 1'b1;
        pulse();
        do_check("lit_w4_shl1", 32'(q_e4),   32'hD);
        do_check("lit_w4_qsr1", 32'(qsr_e4), 32'h1);
        pulse();
        do_check("lit_w4_shl2", 32'(q_e4),   32'hE);
        do_check("lit_w4_qsl2", 32'(qsl_e4), 32'h0);

        // Randomised traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            cen   = ($urandom_range(0, 2) == 0);
            s     = 2'($urandom_range(0, 3));
            dsra  = 1'($urandom_range(0, 1));
            dsrb  = ($urandom_range(0, 3) != 0);
            dsl   = 1'($urandom_range(0, 1));
            d     = 8'($urandom);
            mrn   = ($urandom_range(0, 49) != 0);
            rst_n = ($urandom_range(0, 199) != 0);
            tick(1);
        end

        rst_n = 1'b1; mrn = 1'b1; cen = 1'b0;
        tick(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
